// File: rtl/note_detector.sv
// Measures the period of a square-wave tone pin, decodes it to a fullnote code
// (octave*12 + note), and publishes it after a run of identical decodes.
module note_detector #(
  parameter int STABLE_COUNT = 3,
  parameter int TIMEOUT      = 300000,
  parameter int LO_LIMIT     = 264,
  parameter int HI_LIMIT     = 527
) (
  input  logic       clk,
  input  logic       RESET_n,
  input  logic       tone_in,
  output logic [5:0] note_code,
  output logic [2:0] octave,
  output logic [3:0] note,
  output logic       note_valid,
  output logic       silent,
  output logic       note_strobe
);

  // state     | meaning
  // S_IDLE    | no reference edge yet, waiting for the first rising edge
  // S_MEASURE | period counter running, next edge captures P
  // S_NORM    | octave search, one shift amount per cycle
  // S_MATCH   | walk the note midpoint thresholds from A downward
  // S_CONFIRM | update candidate/stability and publish when stable
  typedef enum logic [2:0] {S_IDLE, S_MEASURE, S_NORM, S_MATCH, S_CONFIRM} state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_sync;
  logic        r_prev, r_edge;
  logic [19:0] r_cnt;
  logic [18:0] r_h;
  logic [2:0]  r_oct;
  logic [9:0]  r_m;
  logic [3:0]  r_k, r_note_dec;
  logic        r_none;
  logic [6:0]  r_cand;
  logic [3:0]  r_stable;
  logic [5:0]  r_code;
  logic [2:0]  r_octave;
  logic [3:0]  r_note;
  logic        r_valid, r_strobe;

  logic [18:0] w_m;
  logic [9:0]  w_thr;
  logic [5:0]  w_code;
  logic [6:0]  w_cand;
  logic [3:0]  w_stable_nxt;
  logic        w_timeout, w_m_lo_ok, w_m_hi_bad, w_hit, w_same;
  logic        w_norm_ok, w_norm_oor, w_match_done, w_publish;

  function automatic logic [9:0] f_thr(input logic [3:0] k);
    case (k)
      4'd0:    f_thr = 10'd497;
      4'd1:    f_thr = 10'd469;
      4'd2:    f_thr = 10'd443;
      4'd3:    f_thr = 10'd418;
      4'd4:    f_thr = 10'd395;
      4'd5:    f_thr = 10'd373;
      4'd6:    f_thr = 10'd352;
      4'd7:    f_thr = 10'd332;
      4'd8:    f_thr = 10'd313;
      4'd9:    f_thr = 10'd295;
      default: f_thr = 10'd279;
    endcase
  endfunction

  assign w_m        = r_h >> (4'd8 - {1'b0, r_oct});
  assign w_m_lo_ok  = (w_m >= 19'(LO_LIMIT));
  assign w_m_hi_bad = (w_m > 19'(HI_LIMIT));
  assign w_thr      = f_thr(r_k);
  assign w_hit      = (r_m >= w_thr);
  assign w_timeout  = (r_cnt == 20'(TIMEOUT));
  // octave*12 + note, deliberately truncated to 6 bits
  assign w_code     = {1'b0, r_oct, 2'b00} * 6'd3 + {2'b00, r_note_dec};
  assign w_cand     = r_none ? 7'h40 : {1'b0, w_code};
  assign w_same     = (r_stable != 4'd0) && (r_cand == w_cand);
  assign w_stable_nxt = !w_same ? 4'd1 :
                        (r_stable >= 4'(STABLE_COUNT)) ? r_stable : r_stable + 4'd1;

  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_timeout) w_next = S_IDLE;
    else begin
      case (r_state)
        S_IDLE:    if (r_edge) w_next = S_MEASURE;
        S_MEASURE: if (r_edge) w_next = S_NORM;
        S_NORM: begin
          if (w_norm_ok)       w_next = S_MATCH;
          else if (w_norm_oor) w_next = S_CONFIRM;
        end
        S_MATCH:   if (w_match_done) w_next = S_CONFIRM;
        S_CONFIRM: w_next = S_MEASURE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_norm_ok    = 1'b0;
    w_norm_oor   = 1'b0;
    w_match_done = 1'b0;
    w_publish    = 1'b0;
    case (r_state)
      S_NORM: begin
        w_norm_ok  = w_m_lo_ok && !w_m_hi_bad;
        w_norm_oor = w_m_lo_ok ? w_m_hi_bad : (r_oct == 3'd5);
      end
      S_MATCH:   w_match_done = w_hit || (r_k == 4'd10);
      S_CONFIRM: w_publish    = (w_stable_nxt >= 4'(STABLE_COUNT));
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      r_sync     <= 2'b00;
      r_prev     <= 1'b0;
      r_edge     <= 1'b0;
      r_cnt      <= '0;
      r_h        <= '0;
      r_oct      <= '0;
      r_m        <= '0;
      r_k        <= '0;
      r_note_dec <= '0;
      r_none     <= 1'b0;
      r_cand     <= '0;
      r_stable   <= '0;
      r_code     <= '0;
      r_octave   <= '0;
      r_note     <= '0;
      r_valid    <= 1'b0;
      r_strobe   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], tone_in};
      r_prev   <= r_sync[1];
      r_edge   <= r_sync[1] & ~r_prev;
      r_strobe <= 1'b0;
      if (r_edge)             r_cnt <= 20'd1;
      else if (r_cnt != '1)   r_cnt <= r_cnt + 20'd1;
      if (w_timeout) begin
        r_stable <= '0;
        r_cand   <= '0;
        if (r_valid) begin
          r_valid  <= 1'b0;
          r_strobe <= 1'b1;
        end
      end else begin
        case (r_state)
          S_MEASURE: if (r_edge) begin
            r_h    <= r_cnt[19:1];
            r_oct  <= '0;
            r_none <= 1'b0;
          end
          S_NORM: begin
            if (w_norm_ok) begin
              r_m <= w_m[9:0];
              r_k <= '0;
            end else if (w_norm_oor) r_none <= 1'b1;
            else                     r_oct  <= r_oct + 3'd1;
          end
          S_MATCH: begin
            if (w_hit)              r_note_dec <= r_k;
            else if (r_k == 4'd10)  r_note_dec <= 4'd11;
            else                    r_k        <= r_k + 4'd1;
          end
          S_CONFIRM: begin
            r_cand   <= w_cand;
            r_stable <= w_stable_nxt;
            if (w_publish) begin
              if (r_none) begin
                if (r_valid) begin
                  r_valid  <= 1'b0;
                  r_strobe <= 1'b1;
                end
              end else begin
                if (!r_valid || (w_code != r_code)) r_strobe <= 1'b1;
                r_valid  <= 1'b1;
                r_code   <= w_code;
                r_octave <= r_oct;
                r_note   <= r_note_dec;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign note_code   = r_code;
  assign octave      = r_octave;
  assign note        = r_note;
  assign note_valid  = r_valid;
  assign silent      = ~r_valid;
  assign note_strobe = r_strobe;

endmodule

// File: tb/tb_note_detector.sv
// Drives whole tone periods into note_detector and compares the published note
// state against a period-level reference model after every rising edge.
module tb_note_detector;

  localparam int TO = 6000;
  localparam int REFS [12] = '{512, 483, 456, 431, 406, 384, 362, 342, 323, 304, 287, 271};

  logic       clk = 1'b0;
  logic       RESET_n = 1'b0;
  logic       tone_in = 1'b0;
  logic [5:0] note_code;
  logic [2:0] octave;
  logic [3:0] note;
  logic       note_valid, silent, note_strobe;

  int n_vec = 0, n_err = 0, n_strobe = 0;
  int m_armed, m_cand, m_cnt, m_valid, m_code, m_oct, m_note, m_strobes = 0;
  int prev_len = 0;

  note_detector #(.TIMEOUT(TO)) dut (
    .clk(clk), .RESET_n(RESET_n), .tone_in(tone_in),
    .note_code(note_code), .octave(octave), .note(note),
    .note_valid(note_valid), .silent(silent), .note_strobe(note_strobe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (note_strobe === 1'b1) n_strobe++;

  // Returns octave*12+note, or -1 when the period is out of range.
  function automatic int decode(input int p);
    int h, m;
    h = p / 2;
    for (int o = 0; o < 6; o++) begin
      m = h / (1 << (8 - o));
      if (m >= 264) begin
        if (m > 527) return -1;
        for (int k = 0; k < 11; k++)
          if (m >= (REFS[k] + REFS[k+1]) / 2) return o * 12 + k;
        return o * 12 + 11;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_armed = 0; m_cand = -2; m_cnt = 0;
    m_valid = 0; m_code = 0; m_oct = 0; m_note = 0;
  endtask

  task automatic model_edge();
    int d, key;
    if (m_armed == 0) m_armed = 1;
    else begin
      d   = decode(prev_len);
      key = (d < 0) ? -1 : d % 64;
      if (m_cnt > 0 && key == m_cand) begin
        if (m_cnt < 3) m_cnt++;
      end else begin
        m_cand = key;
        m_cnt  = 1;
      end
      if (m_cnt >= 3) begin
        if (key < 0) begin
          if (m_valid != 0) begin m_valid = 0; m_strobes++; end
        end else begin
          if (m_valid == 0 || m_code != key) m_strobes++;
          m_valid = 1; m_code = key; m_oct = d / 12; m_note = d % 12;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, " note_valid"},  32'(note_valid), 32'(m_valid));
    chk({ph, " silent"},      32'(silent),     32'(m_valid == 0));
    chk({ph, " note_code"},   32'(note_code),  32'(m_code));
    chk({ph, " octave"},      32'(octave),     32'(m_oct));
    chk({ph, " note"},        32'(note),       32'(m_note));
    chk({ph, " strobes"},     32'(n_strobe),   32'(m_strobes));
  endtask

  task automatic check_reset(input string ph);
    chk({ph, " note_valid"},  32'(note_valid),  32'd0);
    chk({ph, " silent"},      32'(silent),      32'd1);
    chk({ph, " note_code"},   32'(note_code),   32'd0);
    chk({ph, " octave"},      32'(octave),      32'd0);
    chk({ph, " note"},        32'(note),        32'd0);
    chk({ph, " note_strobe"}, 32'(note_strobe), 32'd0);
  endtask

  task automatic play(input int hi, input int lo, input string ph);
    tone_in = 1'b1;
    model_edge();
    repeat (hi) @(negedge clk);
    check_all(ph);
    tone_in = 1'b0;
    repeat (lo) @(negedge clk);
    prev_len = hi + lo;
  endtask

  initial begin
    int h1, h2, h3, h4, h5, gap;
    model_reset();
    h1 = int'($urandom_range(2120, 2220));
    h2 = int'($urandom_range(2240, 2340));
    h3 = int'($urandom_range(2120, 2220));
    h4 = int'($urandom_range(2370, 2490));
    h5 = int'($urandom_range(2120, 2490));

    repeat (5) @(negedge clk);
    check_reset("in_reset");
    RESET_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("post_reset");

    // lock, then switch to a different note
    for (int i = 0; i < 4; i++) play(h1, h1 + int'($urandom_range(0, 1)), "lock1");
    for (int i = 0; i < 3; i++) play(h2, h2 + int'($urandom_range(0, 1)), "switch");
    // alternating notes never become stable
    play(h3, h3, "alt_a");
    play(h4, h4 + 1, "alt_b");
    play(h3, h3 + 1, "alt_c");

    // reset lands while the previous period is in the note-threshold walk
    tone_in = 1'b1;
    repeat (14) @(negedge clk);
    RESET_n = 1'b0;
    #1;
    check_reset("async_reset");
    model_reset();
    tone_in = 1'b0;
    @(negedge clk);
    check_reset("reset_next_clk");
    repeat (2) @(negedge clk);
    RESET_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) play(h5, h5 + int'($urandom_range(0, 1)), "relock");

    // silence: no edge for longer than the timeout
    gap = TO - prev_len + 300;
    repeat (gap) @(negedge clk);
    m_armed = 0; m_cand = -2; m_cnt = 0;
    if (m_valid != 0) begin m_valid = 0; m_strobes++; end
    check_all("timeout");

    // period far below the lowest accepted note
    for (int i = 0; i < 4; i++) play(500, 500, "too_short");
    repeat (20) @(negedge clk);
    check_all("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
